// File: rtl/jb_dl_fhbuf_align.sv
// Per-carrier fronthaul-to-DFE alignment buffer: hunts for start-of-frame, pre-fills a FIFO,
// waits for the DL DFE frame marker, then releases one sample per carrier strobe.
module jb_dl_fhbuf_align #(
    parameter int PRECISION = 16,
    parameter int ADDR_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic                   clk_1x,
    input  logic                   resetn_1x,
    input  logic                   enable,
    input  logic [ADDR_W:0]        fill_thresh,
    input  logic                   clr_stats,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [2*PRECISION-1:0] s_tdata,
    input  logic                   s_tuser,
    input  logic                   dl_dfe_frm_mrkr,
    input  logic                   clk_x1en,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [2*PRECISION-1:0] m_tdata,
    output logic                   m_tuser,
    output logic [2:0]             state,
    output logic [ADDR_W:0]        fifo_level,
    output logic                   underflow_sticky,
    output logic [CNT_W-1:0]       underflow_cnt
);

    localparam int DW    = 2 * PRECISION;
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SOF  = 3'd1,
        ST_FILL      = 3'd2,
        ST_WAIT_MRKR = 3'd3,
        ST_STREAM    = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [DW:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_m_tvalid;
    logic [DW-1:0]     r_m_tdata;
    logic              r_m_tuser;
    logic              r_sticky;
    logic [CNT_W-1:0]  r_cnt;

    logic w_full;
    logic w_empty;
    logic w_s_tready;
    logic w_accept;
    logic w_push;
    logic w_pop_due;
    logic w_pop;
    logic w_underflow;
    logic w_flush;

    assign w_full      = (r_level == LVL_FULL);
    assign w_empty     = (r_level == '0);
    assign w_s_tready  = enable && (r_state != ST_IDLE) && !w_full;
    assign w_accept    = s_tvalid && w_s_tready;

    // A strobe only counts as a pop slot when the output register can take a new sample.
    assign w_pop_due   = enable && (r_state == ST_STREAM) && clk_x1en && (!r_m_tvalid || m_tready);
    assign w_pop       = w_pop_due && !w_empty;
    assign w_underflow = w_pop_due && w_empty;
    assign w_flush     = !enable || w_underflow;

    always_comb begin
        w_push = 1'b0;
        case (r_state)
            ST_WAIT_SOF:                     w_push = w_accept && s_tuser;
            ST_FILL, ST_WAIT_MRKR, ST_STREAM: w_push = w_accept;
            default:                         w_push = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:      w_state_next = ST_WAIT_SOF;
                ST_WAIT_SOF:  if (w_accept && s_tuser) w_state_next = ST_FILL;
                ST_FILL:      if (r_level >= fill_thresh) w_state_next = ST_WAIT_MRKR;
                ST_WAIT_MRKR: if (dl_dfe_frm_mrkr) w_state_next = ST_STREAM;
                ST_STREAM:    if (w_underflow) w_state_next = ST_WAIT_SOF;
                default:      w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_1x or negedge resetn_1x) begin
        if (!resetn_1x) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sample storage carries the SOF flag alongside the IQ word; no reset so it maps to RAM.
    always_ff @(posedge clk_1x) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_tuser, s_tdata};
        end
    end

    always_ff @(posedge clk_1x or negedge resetn_1x) begin
        if (!resetn_1x) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Output register doubles as the RAM read register; data is held while stalled.
    always_ff @(posedge clk_1x or negedge resetn_1x) begin
        if (!resetn_1x) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tuser  <= 1'b0;
        end else if (!enable) begin
            r_m_tvalid <= 1'b0;
        end else if (w_pop) begin
            r_m_tvalid             <= 1'b1;
            {r_m_tuser, r_m_tdata} <= r_mem[r_rd_ptr];
        end else if (r_m_tvalid && m_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk_1x or negedge resetn_1x) begin
        if (!resetn_1x) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (clr_stats) begin
            r_sticky <= w_underflow;
            r_cnt    <= w_underflow ? CNT_ONE : '0;
        end else if (w_underflow) begin
            r_sticky <= 1'b1;
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign s_tready         = w_s_tready;
    assign m_tvalid         = r_m_tvalid;
    assign m_tdata          = r_m_tdata;
    assign m_tuser          = r_m_tuser;
    assign state            = r_state;
    assign fifo_level       = r_level;
    assign underflow_sticky = r_sticky;
    assign underflow_cnt    = r_cnt;

endmodule

// File: tb/tb_jb_dl_fhbuf_align.sv
// Bench for jb_dl_fhbuf_align: queue-based behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_jb_dl_fhbuf_align;

    localparam int P     = 16;
    localparam int AW    = 3;
    localparam int CW    = 4;
    localparam int DW    = 2 * P;
    localparam int DEPTH = 2 ** AW;
    localparam int CMAX  = 2 ** CW - 1;

    logic          clk_1x = 1'b0;
    logic          resetn_1x = 1'b0;
    logic          enable = 1'b0;
    logic [AW:0]   fill_thresh = 4'd4;
    logic          clr_stats = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tuser = 1'b0;
    logic          dl_dfe_frm_mrkr = 1'b0;
    logic          clk_x1en = 1'b0;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tuser;
    logic [2:0]    state;
    logic [AW:0]   fifo_level;
    logic          underflow_sticky;
    logic [CW-1:0] underflow_cnt;

    jb_dl_fhbuf_align #(.PRECISION(P), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk_1x           (clk_1x),
        .resetn_1x        (resetn_1x),
        .enable           (enable),
        .fill_thresh      (fill_thresh),
        .clr_stats        (clr_stats),
        .s_tvalid         (s_tvalid),
        .s_tready         (s_tready),
        .s_tdata          (s_tdata),
        .s_tuser          (s_tuser),
        .dl_dfe_frm_mrkr  (dl_dfe_frm_mrkr),
        .clk_x1en         (clk_x1en),
        .m_tvalid         (m_tvalid),
        .m_tready         (m_tready),
        .m_tdata          (m_tdata),
        .m_tuser          (m_tuser),
        .state            (state),
        .fifo_level       (fifo_level),
        .underflow_sticky (underflow_sticky),
        .underflow_cnt    (underflow_cnt)
    );

    always #5 clk_1x = ~clk_1x;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            e_st;
    logic [DW:0]   q[$];
    bit            e_mv;
    logic [DW-1:0] e_md;
    bit            e_mu;
    bit            e_sticky;
    int            e_cnt;

    function automatic bit e_tready();
        return enable && (e_st != 0) && (q.size() != DEPTH);
    endfunction

    always @(posedge clk_1x or negedge resetn_1x) begin : model
        bit acc;
        bit due;
        bit uf;
        int lvl0;
        if (!resetn_1x) begin
            e_st = 0; q.delete(); e_mv = 0; e_md = '0; e_mu = 0; e_sticky = 0; e_cnt = 0;
        end else begin
            acc  = s_tvalid && e_tready();
            lvl0 = q.size();
            due  = enable && (e_st == 4) && clk_x1en && (!e_mv || m_tready);
            uf   = due && (lvl0 == 0);
            if (clr_stats) begin
                e_sticky = uf;
                e_cnt    = uf ? 1 : 0;
            end else if (uf) begin
                e_sticky = 1;
                if (e_cnt < CMAX) e_cnt++;
            end
            if (!enable) begin
                e_st = 0; q.delete(); e_mv = 0;
            end else begin
                if (e_mv && m_tready) e_mv = 0;
                case (e_st)
                    0: e_st = 1;
                    1: if (acc && s_tuser) begin q.push_back({s_tuser, s_tdata}); e_st = 2; end
                    2: begin
                        if (acc) q.push_back({s_tuser, s_tdata});
                        if (lvl0 >= int'(fill_thresh)) e_st = 3;
                    end
                    3: begin
                        if (acc) q.push_back({s_tuser, s_tdata});
                        if (dl_dfe_frm_mrkr) e_st = 4;
                    end
                    default: begin
                        if (uf) begin
                            q.delete(); e_mv = 0; e_st = 1;
                        end else begin
                            if (due) begin
                                {e_mu, e_md} = q.pop_front();
                                e_mv = 1;
                            end
                            if (acc) q.push_back({s_tuser, s_tdata});
                        end
                    end
                endcase
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_1x) begin
        chk("s_tready", 64'(s_tready), 64'(e_tready()));
        chk("m_tvalid", 64'(m_tvalid), 64'(e_mv));
        if (e_mv) begin
            chk("m_tdata", 64'(m_tdata), 64'(e_md));
            chk("m_tuser", 64'(m_tuser), 64'(e_mu));
        end
        chk("state", 64'(state), 64'(e_st));
        chk("fifo_level", 64'(fifo_level), 64'(q.size()));
        chk("sticky", 64'(underflow_sticky), 64'(e_sticky));
        chk("cnt", 64'(underflow_cnt), 64'(e_cnt));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk_1x);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit u);
        int guard;
        guard = 0;
        s_tvalid = 1'b1; s_tdata = d; s_tuser = u;
        while (!s_tready && guard < 50) begin
            step();
            guard++;
        end
        chk("send_ready", 64'(s_tready), 64'(1));
        step();
        s_tvalid = 1'b0; s_tuser = 1'b0;
    endtask

    task automatic strobe();
        clk_x1en = 1'b1;
        step();
        clk_x1en = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s);
        int guard;
        guard = 0;
        while (state != s && guard < 50) begin
            step();
            guard++;
        end
        chk("wait_state", 64'(state), 64'(s));
    endtask

    task automatic prime(input logic [DW-1:0] base, input int n, input int thr);
        fill_thresh = (AW + 1)'(thr);
        send(base, 1'b1);
        for (int i = 1; i < n; i++) send(base + DW'(i), 1'b0);
        wait_state(3'd3);
        dl_dfe_frm_mrkr = 1'b1;
        step();
        dl_dfe_frm_mrkr = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_tready"}, 64'(s_tready), 64'(0));
        chk({tag, "_m_tvalid"}, 64'(m_tvalid), 64'(0));
        chk({tag, "_m_tdata"}, 64'(m_tdata), 64'(0));
        chk({tag, "_m_tuser"}, 64'(m_tuser), 64'(0));
        chk({tag, "_state"}, 64'(state), 64'(0));
        chk({tag, "_level"}, 64'(fifo_level), 64'(0));
        chk({tag, "_sticky"}, 64'(underflow_sticky), 64'(0));
        chk({tag, "_cnt"}, 64'(underflow_cnt), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        logic [DW-1:0] exp_d[4];
        bit            exp_u[4];
        logic [DW-1:0] d;
        bit            rdy;
        exp_d = '{32'h10, 32'h11, 32'h12, 32'h13};
        exp_u = '{1'b1, 1'b0, 1'b0, 1'b0};

        step(2);
        chk_all_zero("reset");
        resetn_1x = 1'b1;
        enable = 1'b1;
        fill_thresh = 4'd4;
        step();
        chk("idle_to_wait_sof", 64'(state), 64'(1));

        // SOF hunt
        for (int i = 1; i <= 5; i++) send(DW'(i), 1'b0);
        chk("sof_drop_level", 64'(fifo_level), 64'(0));
        send(32'h10, 1'b1);
        for (int i = 1; i <= 3; i++) send(32'h10 + DW'(i), 1'b0);
        step();
        chk("sof_state", 64'(state), 64'(3));
        chk("sof_level", 64'(fifo_level), 64'(4));
        step(3);
        chk("no_out_before_mrkr", 64'(m_tvalid), 64'(0));

        // Marker release
        m_tready = 1'b1;
        dl_dfe_frm_mrkr = 1'b1;
        step();
        dl_dfe_frm_mrkr = 1'b0;
        chk("mrkr_stream", 64'(state), 64'(4));
        step(2);
        chk("no_out_before_strobe", 64'(m_tvalid), 64'(0));
        for (int i = 0; i < 4; i++) begin
            strobe();
            $display("release %0d: m_tvalid=%0d m_tdata=0x%0h m_tuser=%0d", i, m_tvalid, m_tdata, m_tuser);
            chk("rel_valid", 64'(m_tvalid), 64'(1));
            chk("rel_data", 64'(m_tdata), 64'(exp_d[i]));
            chk("rel_user", 64'(m_tuser), 64'(exp_u[i]));
            step(3);
        end

        // Underflow on the 5th strobe
        strobe();
        chk("uf_valid", 64'(m_tvalid), 64'(0));
        chk("uf_sticky", 64'(underflow_sticky), 64'(1));
        chk("uf_cnt", 64'(underflow_cnt), 64'(1));
        chk("uf_state", 64'(state), 64'(1));
        chk("uf_level", 64'(fifo_level), 64'(0));

        // Full FIFO and backpressure
        fill_thresh = 4'd8;
        send(32'h20, 1'b1);
        d = 32'h21;
        s_tvalid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s_tdata = d;
            rdy = s_tready;
            step();
            if (rdy) d = d + 1;
        end
        s_tvalid = 1'b0;
        chk("full_level", 64'(fifo_level), 64'(8));
        chk("full_tready", 64'(s_tready), 64'(0));
        chk("full_state", 64'(state), 64'(3));
        m_tready = 1'b0;
        dl_dfe_frm_mrkr = 1'b1;
        step();
        dl_dfe_frm_mrkr = 1'b0;
        strobe();
        chk("bp_first", 64'(m_tdata), 64'(32'h20));
        for (int i = 0; i < 3; i++) begin
            step();
            strobe();
            chk("bp_hold_valid", 64'(m_tvalid), 64'(1));
            chk("bp_hold_data", 64'(m_tdata), 64'(32'h20));
            chk("bp_hold_level", 64'(fifo_level), 64'(7));
            chk("bp_hold_cnt", 64'(underflow_cnt), 64'(1));
        end
        m_tready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            strobe();
            chk("drain_data", 64'(m_tdata), 64'(32'h20 + i));
        end
        strobe();
        chk("drain_uf_cnt", 64'(underflow_cnt), 64'(2));

        // Enable drop mid-STREAM
        prime(32'h30, 2, 2);
        strobe();
        chk("en_pre_valid", 64'(m_tvalid), 64'(1));
        m_tready = 1'b0;
        enable = 1'b0;
        step();
        chk("en_state", 64'(state), 64'(0));
        chk("en_level", 64'(fifo_level), 64'(0));
        chk("en_valid", 64'(m_tvalid), 64'(0));
        chk("en_tready", 64'(s_tready), 64'(0));
        chk("en_cnt_kept", 64'(underflow_cnt), 64'(2));
        m_tready = 1'b1;
        enable = 1'b1;
        step();

        // clr_stats alone, then coincident with an underflow
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        chk("clr_sticky", 64'(underflow_sticky), 64'(0));
        chk("clr_cnt", 64'(underflow_cnt), 64'(0));
        prime(32'h40, 1, 1);
        strobe();
        prime_clr: begin
            clk_x1en = 1'b1;
            step();
            clk_x1en = 1'b0;
        end
        chk("pre_clr_cnt", 64'(underflow_cnt), 64'(1));
        prime(32'h41, 1, 1);
        strobe();
        clr_stats = 1'b1;
        clk_x1en = 1'b1;
        step();
        clr_stats = 1'b0;
        clk_x1en = 1'b0;
        chk("clr_uf_sticky", 64'(underflow_sticky), 64'(1));
        chk("clr_uf_cnt", 64'(underflow_cnt), 64'(1));

        // Counter saturation
        for (int k = 0; k < CMAX + 2; k++) begin
            prime(32'h50 + DW'(k), 1, 1);
            strobe();
            strobe();
        end
        chk("sat_cnt", 64'(underflow_cnt), 64'(CMAX));
        chk("sat_sticky", 64'(underflow_sticky), 64'(1));

        // Asynchronous reset mid-STREAM
        prime(32'h60, 3, 3);
        strobe();
        chk("ar_pre_valid", 64'(m_tvalid), 64'(1));
        #3;
        resetn_1x = 1'b0;
        #1;
        chk_all_zero("areset");
        step(2);
        chk("ar_held_valid", 64'(m_tvalid), 64'(0));
        resetn_1x = 1'b1;
        step();
        chk("ar_restart_state", 64'(state), 64'(1));
        prime(32'h70, 2, 2);
        strobe();
        chk("ar_first_data", 64'(m_tdata), 64'(32'h70));
        chk("ar_first_user", 64'(m_tuser), 64'(1));
        strobe();
        chk("ar_second_data", 64'(m_tdata), 64'(32'h71));
        strobe();
        chk("ar_uf_cnt", 64'(underflow_cnt), 64'(1));
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
